mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//   MEM-stage data-memory unit. Sits between the EX/MEM register and the MEM/WB register.
//   Performs word, halfword and byte loads and stores against an internal synchronous RAM.
//   Each access has a fixed multi-cycle latency; while an access is in flight the unit raises
//   MEM_Stall, and the pipeline freezes upstream stages.
//   The load result drives MEM_MemData into the MEM/WB register.
// PARAMETERS
//   DEPTH_WORDS  1024  number of 32-bit words in the RAM (power of 2)
//   ADDR_W       10    log2(DEPTH_WORDS); word index = MEM_ALUResult[ADDR_W+1:2]
//   LATENCY      2     stall cycles per access, counting the accept cycle; legal range 1..15
// PORTS
//   Clk            in   1   clock; all state changes on the rising edge
//   Reset          in   1   asynchronous, active-high reset
//   MEM_MemRead    in   1   load request
//   MEM_MemWrite   in   1   store request
//   MEM_MemSize    in   2   00 = word, 01 = half, 10 = byte, 11 = treated as word
//   MEM_MemSigned  in   1   1 = sign-extend a half/byte load, 0 = zero-extend
//   MEM_ALUResult  in   32  byte address
//   MEM_WriteData  in   32  store data; low bytes are used for half/byte stores
//   MEM_MemData    out  32  load result; registered
//   MEM_Stall      out  1   1 = hold the pipeline; inputs stay stable while it is high
//   MEM_AlignErr   out  1   one-cycle pulse when an access is misaligned
// BEHAVIOUR
//   Reset (async): state = IDLE, MEM_MemData = 0, MEM_Stall = 0, MEM_AlignErr = 0, counter = 0.
//     A pending store is discarded. RAM contents are not cleared.
//   FSM states: IDLE, BUSY, DONE.
//   - IDLE: a request is accepted when MemRead or MemWrite is high.
//     - If both are high, the access is a store and MEM_MemData is loaded with 0 at completion.
//     - On accept: latch address, data, size and signed; counter = LATENCY-1.
//     - On accept: MEM_Stall = 1 combinationally in that same cycle.
//     - LATENCY = 1: go to DONE. Otherwise go to BUSY.
//   - BUSY: MEM_Stall = 1; counter decrements every cycle; go to DONE when counter == 1.
//   - Edge into DONE (completion edge):
//     - a store writes the RAM;
//     - a load registers the extended data into MEM_MemData.
//   - DONE: MEM_Stall = 0; MEM_MemData is valid; the pipeline advances at the end of this cycle.
//     - Next state is IDLE unconditionally, so the still-present request is not re-accepted.
//   Timing: MEM_Stall is high for exactly LATENCY cycles. Load data is valid LATENCY cycles
//     after the accept cycle.
//   MEM_MemData holds its value until the next completed load, including across stores and idle cycles.
//   Alignment rules:
//     - word access needs addr[1:0] == 0; half access needs addr[0] == 0.
//     - A violation is rejected in IDLE: no stall, no RAM access, MEM_AlignErr = 1 for that cycle,
//       MEM_MemData = 0 at the next edge.
//   Byte lanes are little-endian:
//     - byte lane = addr[1:0]; half lane = addr[1].
//     - Stores modify only the addressed bytes (read-modify-write is not allowed; use byte enables).
//   Extension: byte loads extend bit 7; half loads extend bit 15; MemSigned selects sign or zero.
//   Address bits above ADDR_W+1 are ignored, so accesses wrap modulo DEPTH_WORDS*4.
//   Reset asserted in BUSY or DONE aborts the access immediately; a store is not committed
//     unless its completion edge has already occurred.
// TESTING
//   1. Word store 0xDEADBEEF to 0x10 then word load 0x10 (LATENCY=2)
//      -> Stall high 2 cycles each; MemData = 0xDEADBEEF in DONE.
//   2. Byte store 0x7F to 0x13, then signed byte load 0x13, then word load 0x10
//      -> 0x0000007F, then 0x7FADBEEF.
//   3. Signed half load of 0x8001 at 0x12 -> 0xFFFF8001; unsigned load -> 0x00008001.
//   4. Word load at 0x06 -> AlignErr pulse, Stall 0, MemData = 0, RAM unchanged.
//   5. Store to 0x10 with Reset pulsed during BUSY -> state IDLE, Stall 0, word 0x10 still holds old value.
//   6. Load at 0x1010 with DEPTH_WORDS=1024 -> returns word 0x10;
//      LATENCY=1 build -> Stall high exactly 1 cycle.

Source files
------------

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//   MEM-stage data-memory unit between the EX/MEM and MEM/WB registers.
//   It performs word, halfword and byte loads and stores against an internal
//   RAM. Every access takes a fixed number of cycles. While an access is in
//   flight, MEM_Stall is held high so that the upstream stages freeze.
//
// Ports
//   Clk            clock; all state changes on the rising edge
//   Reset          asynchronous, active-high reset
//   MEM_MemRead    load request
//   MEM_MemWrite   store request (a store wins if both requests are high)
//   MEM_MemSize    00 word, 01 half, 10 byte, 11 word
//   MEM_MemSigned  1 = sign-extend half/byte loads, 0 = zero-extend
//   MEM_ALUResult  byte address (bits above ADDR_W+1 are ignored)
//   MEM_WriteData  store data; the low bytes are used for half/byte stores
//   MEM_MemData    registered load result, held until the next load completes
//   MEM_Stall      high while an access is in flight (exactly LATENCY cycles)
//   MEM_AlignErr   one-cycle pulse when a misaligned request is rejected
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10,
  parameter int LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [1:0]  MEM_MemSize,
  input  logic        MEM_MemSigned,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_WriteData,
  output logic [31:0] MEM_MemData,
  output logic        MEM_Stall,
  output logic        MEM_AlignErr
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, next_state;
  logic [3:0] count;

  logic [ADDR_W-1:0] lat_index;
  logic [1:0]        lat_lane;
  logic [31:0]       lat_wdata;
  logic [1:0]        lat_size;
  logic              lat_signed;
  logic              lat_store;
  logic              lat_load;

  logic [3:0][7:0] mem [DEPTH_WORDS];

  logic              request;
  logic              misaligned;
  logic              accept;
  logic              complete;

  logic [ADDR_W-1:0] cur_index;
  logic [1:0]        cur_lane;
  logic [31:0]       cur_wdata;
  logic [1:0]        cur_size;
  logic              cur_signed;
  logic              cur_store;
  logic              cur_load;

  logic [31:0]       rd_word;
  logic [31:0]       load_ext;
  logic [15:0]       sel_half;
  logic [7:0]        sel_byte;
  logic [3:0]        byte_en;
  logic [3:0][7:0]   wr_data;

  // Upper address bits are deliberately dropped so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^MEM_ALUResult[31:ADDR_W+2];

  assign request = MEM_MemRead | MEM_MemWrite;
  assign accept  = (state == IDLE) && request && !misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (MEM_MemSize)
      2'b01:   misaligned = MEM_ALUResult[0];
      2'b10:   misaligned = 1'b0;
      default: misaligned = (MEM_ALUResult[1:0] != 2'b00);
    endcase
  end

  // In IDLE the access still comes straight from the inputs. With
  // LATENCY = 1, the completion edge is the accept edge itself. After that,
  // the latched copy is used.
  always_comb begin
    if (state == IDLE) begin
      cur_index  = MEM_ALUResult[ADDR_W+1:2];
      cur_lane   = MEM_ALUResult[1:0];
      cur_wdata  = MEM_WriteData;
      cur_size   = MEM_MemSize;
      cur_signed = MEM_MemSigned;
      cur_store  = MEM_MemWrite;
      cur_load   = MEM_MemRead;
    end else begin
      cur_index  = lat_index;
      cur_lane   = lat_lane;
      cur_wdata  = lat_wdata;
      cur_size   = lat_size;
      cur_signed = lat_signed;
      cur_store  = lat_store;
      cur_load   = lat_load;
    end
  end

  // Next-state logic and the combinational stall and alignment outputs.
  always_comb begin
    next_state   = state;
    MEM_Stall    = 1'b0;
    MEM_AlignErr = 1'b0;
    complete     = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          if (misaligned) begin
            MEM_AlignErr = 1'b1;
          end else begin
            MEM_Stall = 1'b1;
            if (LATENCY == 1) begin
              next_state = DONE;
              complete   = 1'b1;
            end else begin
              next_state = BUSY;
            end
          end
        end
      end
      BUSY: begin
        MEM_Stall = 1'b1;
        if (count == 4'd1) begin
          next_state = DONE;
          complete   = 1'b1;
        end
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign rd_word = mem[cur_index];

  // Pick the addressed lane out of the word and extend it.
  always_comb begin
    sel_half = cur_lane[1] ? rd_word[31:16] : rd_word[15:0];
    sel_byte = rd_word[{cur_lane, 3'b000} +: 8];
    load_ext = rd_word;
    case (cur_size)
      2'b01:   load_ext = {{16{cur_signed & sel_half[15]}}, sel_half};
      2'b10:   load_ext = {{24{cur_signed & sel_byte[7]}}, sel_byte};
      default: load_ext = rd_word;
    endcase
  end

  // Replicate the store data across all lanes. The byte enables then pick
  // which lanes are actually written.
  always_comb begin
    byte_en = 4'b1111;
    wr_data = cur_wdata;
    case (cur_size)
      2'b01: begin
        byte_en = cur_lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{cur_wdata[15:0]}};
      end
      2'b10: begin
        byte_en = 4'b0001 << cur_lane;
        wr_data = {4{cur_wdata[7:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wr_data = cur_wdata;
      end
    endcase
  end

  // State register, access latch, latency counter and the registered load
  // result.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      count       <= 4'd0;
      MEM_MemData <= 32'd0;
      lat_index   <= '0;
      lat_lane    <= 2'b00;
      lat_wdata   <= 32'd0;
      lat_size    <= 2'b00;
      lat_signed  <= 1'b0;
      lat_store   <= 1'b0;
      lat_load    <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        lat_index  <= MEM_ALUResult[ADDR_W+1:2];
        lat_lane   <= MEM_ALUResult[1:0];
        lat_wdata  <= MEM_WriteData;
        lat_size   <= MEM_MemSize;
        lat_signed <= MEM_MemSigned;
        lat_store  <= MEM_MemWrite;
        lat_load   <= MEM_MemRead;
        count      <= 4'(LATENCY - 1);
      end else if (state == BUSY) begin
        count <= count - 4'd1;
      end
      if ((state == IDLE) && request && misaligned) begin
        MEM_MemData <= 32'd0;
      end else if (complete) begin
        // A combined read+write request is treated as a store that clears
        // the result. A plain store leaves the last load value untouched.
        if (cur_store) begin
          if (cur_load) MEM_MemData <= 32'd0;
        end else begin
          MEM_MemData <= load_ext;
        end
      end
    end
  end

  // The RAM itself is never reset. Gating the write with Reset keeps an
  // aborted store from landing on the edge where reset is held.
  always_ff @(posedge Clk) begin
    if (complete && cur_store && !Reset) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[cur_index][i] <= wr_data[i];
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//   Directed bench for mem_access_stage. It instantiates two copies of the
//   design: one built with LATENCY = 2 and one built with LATENCY = 1.
//   use_l1 steers the requests to exactly one copy, and the observed outputs
//   are taken from that copy.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic [1:0]  MEM_MemSize;
  logic        MEM_MemSigned;
  logic [31:0] MEM_ALUResult;
  logic [31:0] MEM_WriteData;
  logic        use_l1;

  logic [31:0] data_l2, data_l1;
  logic        stall_l2, stall_l1;
  logic        align_l2, align_l1;

  logic [31:0] obs_data;
  logic        obs_stall;
  logic        obs_align;

  int vectors     = 0;
  int miscompares = 0;

  int          stalls;
  logic        align;
  logic [31:0] done_data;
  logic [31:0] after_data;

  always #5 Clk = ~Clk;

  mem_access_stage #(.DEPTH_WORDS(1024), .ADDR_W(10), .LATENCY(2)) dut_l2 (
    .Clk           (Clk),
    .Reset         (Reset),
    .MEM_MemRead   (MEM_MemRead & ~use_l1),
    .MEM_MemWrite  (MEM_MemWrite & ~use_l1),
    .MEM_MemSize   (MEM_MemSize),
    .MEM_MemSigned (MEM_MemSigned),
    .MEM_ALUResult (MEM_ALUResult),
    .MEM_WriteData (MEM_WriteData),
    .MEM_MemData   (data_l2),
    .MEM_Stall     (stall_l2),
    .MEM_AlignErr  (align_l2)
  );

  mem_access_stage #(.DEPTH_WORDS(1024), .ADDR_W(10), .LATENCY(1)) dut_l1 (
    .Clk           (Clk),
    .Reset         (Reset),
    .MEM_MemRead   (MEM_MemRead & use_l1),
    .MEM_MemWrite  (MEM_MemWrite & use_l1),
    .MEM_MemSize   (MEM_MemSize),
    .MEM_MemSigned (MEM_MemSigned),
    .MEM_ALUResult (MEM_ALUResult),
    .MEM_WriteData (MEM_WriteData),
    .MEM_MemData   (data_l1),
    .MEM_Stall     (stall_l1),
    .MEM_AlignErr  (align_l1)
  );

  assign obs_data  = use_l1 ? data_l1  : data_l2;
  assign obs_stall = use_l1 ? stall_l1 : stall_l2;
  assign obs_align = use_l1 ? align_l1 : align_l2;

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one request just after a rising edge. Sample at each falling edge
  // until the stall drops. done_data is taken in that first non-stalled cycle.
  // after_data is taken one cycle later, after the request has been removed.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] sz,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                               output int n_stall, output logic err,
                               output logic [31:0] d_done, output logic [31:0] d_after);
    int n;
    @(posedge Clk); #1;
    MEM_MemRead   = rd;
    MEM_MemWrite  = wr;
    MEM_MemSize   = sz;
    MEM_MemSigned = sgn;
    MEM_ALUResult = addr;
    MEM_WriteData = wd;
    n_stall = 0;
    err     = 1'b0;
    d_done  = 32'd0;
    for (n = 0; n < 20; n++) begin
      @(negedge Clk);
      if (obs_align) err = 1'b1;
      if (obs_stall) n_stall++;
      else break;
    end
    if (n >= 20) checkOutput("stall_timeout", 32'(n), 32'd0);
    d_done = obs_data;
    @(posedge Clk); #1;
    MEM_MemRead  = 1'b0;
    MEM_MemWrite = 1'b0;
    @(negedge Clk);
    d_after = obs_data;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    use_l1 = 1'b0;
    MEM_MemRead = 1'b0;
    MEM_MemWrite = 1'b0;
    MEM_MemSize = 2'b00;
    MEM_MemSigned = 1'b0;
    MEM_ALUResult = 32'd0;
    MEM_WriteData = 32'd0;
    repeat (2) @(negedge Clk);
    checkOutput("rst_data",  data_l2, 32'd0);
    checkOutput("rst_stall", 32'(stall_l2), 32'd0);
    checkOutput("rst_align", 32'(align_l2), 32'd0);
    Reset = 1'b0;

    // Word store, then word load.
    applyStimulus(0, 1, 2'b00, 0, 32'h10, 32'hDEADBEEF, stalls, align, done_data, after_data);
    checkOutput("t1_st_stalls", 32'(stalls), 32'd2);
    applyStimulus(1, 0, 2'b00, 0, 32'h10, 32'h0, stalls, align, done_data, after_data);
    checkOutput("t1_ld_stalls", 32'(stalls), 32'd2);
    checkOutput("t1_ld_data", done_data, 32'hDEADBEEF);

    // Byte store into the top lane. The result register must hold across it.
    applyStimulus(0, 1, 2'b10, 0, 32'h13, 32'h0000007F, stalls, align, done_data, after_data);
    checkOutput("t2_st_hold", after_data, 32'hDEADBEEF);
    applyStimulus(1, 0, 2'b10, 1, 32'h13, 32'h0, stalls, align, done_data, after_data);
    checkOutput("t2_ldb_s", done_data, 32'h0000007F);
    applyStimulus(1, 0, 2'b00, 0, 32'h10, 32'h0, stalls, align, done_data, after_data);
    checkOutput("t2_ldw", done_data, 32'h7FADBEEF);

    // Half store to the upper lane, then signed and unsigned extension.
    applyStimulus(0, 1, 2'b01, 0, 32'h12, 32'hABCD8001, stalls, align, done_data, after_data);
    applyStimulus(1, 0, 2'b01, 1, 32'h12, 32'h0, stalls, align, done_data, after_data);
    checkOutput("t3_ldh_s", done_data, 32'hFFFF8001);
    applyStimulus(1, 0, 2'b01, 0, 32'h12, 32'h0, stalls, align, done_data, after_data);
    checkOutput("t3_ldh_u", done_data, 32'h00008001);
    applyStimulus(1, 0, 2'b01, 1, 32'h10, 32'h0, stalls, align, done_data, after_data);
    checkOutput("t3_ldh_lo_s", done_data, 32'hFFFFBEEF);
    applyStimulus(1, 0, 2'b10, 1, 32'h11, 32'h0, stalls, align, done_data, after_data);
    checkOutput("t3_ldb_s", done_data, 32'hFFFFFFBE);
    applyStimulus(1, 0, 2'b10, 0, 32'h11, 32'h0, stalls, align, done_data, after_data);
    checkOutput("t3_ldb_u", done_data, 32'h000000BE);
    applyStimulus(1, 0, 2'b00, 0, 32'h10, 32'h0, stalls, align, done_data, after_data);
    checkOutput("t3_ldw", done_data, 32'h8001BEEF);

    // Misaligned accesses are rejected without a stall.
    applyStimulus(1, 0, 2'b00, 0, 32'h06, 32'h0, stalls, align, done_data, after_data);
    checkOutput("t4_w_align", 32'(align), 32'd1);
    checkOutput("t4_w_stalls", 32'(stalls), 32'd0);
    checkOutput("t4_w_data", after_data, 32'd0);
    applyStimulus(0, 1, 2'b01, 0, 32'h11, 32'h0000FFFF, stalls, align, done_data, after_data);
    checkOutput("t4_sth_align", 32'(align), 32'd1);
    checkOutput("t4_sth_stalls", 32'(stalls), 32'd0);
    applyStimulus(1, 0, 2'b01, 0, 32'h13, 32'h0, stalls, align, done_data, after_data);
    checkOutput("t4_ldh_align", 32'(align), 32'd1);
    applyStimulus(1, 0, 2'b00, 0, 32'h10, 32'h0, stalls, align, done_data, after_data);
    checkOutput("t4_ram_kept", done_data, 32'h8001BEEF);
    checkOutput("t4_ok_align", 32'(align), 32'd0);

    // Reset during BUSY aborts a word store before it completes.
    @(posedge Clk); #1;
    MEM_MemWrite  = 1'b1;
    MEM_MemSize   = 2'b00;
    MEM_ALUResult = 32'h10;
    MEM_WriteData = 32'h12345678;
    @(negedge Clk);
    checkOutput("t5_accept_stall", 32'(stall_l2), 32'd1);
    @(posedge Clk); #1;
    checkOutput("t5_busy_stall", 32'(stall_l2), 32'd1);
    Reset = 1'b1;
    MEM_MemWrite = 1'b0;
    #1;
    checkOutput("t5_rst_stall", 32'(stall_l2), 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    checkOutput("t5_rst_data", data_l2, 32'd0);
    checkOutput("t5_rst_stall2", 32'(stall_l2), 32'd0);
    Reset = 1'b0;
    applyStimulus(1, 0, 2'b00, 0, 32'h10, 32'h0, stalls, align, done_data, after_data);
    checkOutput("t5_old_word", done_data, 32'h8001BEEF);

    // Address wrap, plus a combined read+write request.
    applyStimulus(1, 0, 2'b00, 0, 32'h1010, 32'h0, stalls, align, done_data, after_data);
    checkOutput("t6_wrap_ld", done_data, 32'h8001BEEF);
    applyStimulus(0, 1, 2'b00, 0, 32'h1014, 32'hCAFEF00D, stalls, align, done_data, after_data);
    applyStimulus(1, 0, 2'b00, 0, 32'h14, 32'h0, stalls, align, done_data, after_data);
    checkOutput("t6_wrap_st", done_data, 32'hCAFEF00D);
    applyStimulus(1, 1, 2'b00, 0, 32'h18, 32'h11223344, stalls, align, done_data, after_data);
    checkOutput("t6_rw_data", done_data, 32'd0);
    applyStimulus(1, 0, 2'b00, 0, 32'h18, 32'h0, stalls, align, done_data, after_data);
    checkOutput("t6_rw_stored", done_data, 32'h11223344);

    // Single-cycle build.
    use_l1 = 1'b1;
    applyStimulus(0, 1, 2'b00, 0, 32'h20, 32'h55AA0001, stalls, align, done_data, after_data);
    checkOutput("l1_st_stalls", 32'(stalls), 32'd1);
    applyStimulus(1, 0, 2'b00, 0, 32'h20, 32'h0, stalls, align, done_data, after_data);
    checkOutput("l1_ld_stalls", 32'(stalls), 32'd1);
    checkOutput("l1_ld_data", done_data, 32'h55AA0001);
    applyStimulus(1, 0, 2'b10, 0, 32'h22, 32'h0, stalls, align, done_data, after_data);
    checkOutput("l1_ldb_u", done_data, 32'h000000AA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
